// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
//  Module   : assoc_cache
//  Purpose  : 2-way set-associative, write-through, no-write-allocate data
//             cache with per-set LRU, burst refill and byte/half/word access.
//  Revision : 1.0
// ============================================================================
module assoc_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  input  logic                  flush,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_wr_ack
);

  localparam int WW   = $clog2(BLOCK_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int OFF  = WW + 2;
  localparam int TAGW = ADDR_WIDTH - OFF - IDX;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_REFILL  = 3'd2,
    S_RESPOND = 3'd3,
    S_WRITE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [WW-1:0]           cnt_q, cnt_d;
  logic [31:0]             buf_q [BLOCK_WORDS];
  logic [31:0]             buf_d [BLOCK_WORDS];
  logic [1:0][SETS-1:0]    valid_q, valid_d;
  logic [SETS-1:0]         lru_q, lru_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    mem_rd_req_q, mem_rd_req_d;
  logic                    mem_wr_req_q, mem_wr_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_wstrb_q, mem_wstrb_d;

  // Line storage carries no reset; valid bits alone qualify it.
  logic [TAGW-1:0]         tag_q  [2][SETS];
  logic [31:0]             data_q [2][SETS][BLOCK_WORDS];

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic [WW-1:0]   w_word;
  logic            w_hit0, w_hit1, w_hit, w_hit_way, w_victim, w_last;
  logic            w_fill_en, w_st_en;
  logic [31:0]     w_hit_word, w_lane_data;
  logic [3:0]      w_strb;
  logic [31:0]     w_fill_line [BLOCK_WORDS];

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = {{24{~uns & b[7]}}, b};
      2'b01:   load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  assign w_idx      = addr_q[OFF+IDX-1:OFF];
  assign w_tag      = addr_q[ADDR_WIDTH-1:OFF+IDX];
  assign w_word     = addr_q[OFF-1:2];
  assign w_hit0     = valid_q[0][w_idx] && (tag_q[0][w_idx] == w_tag);
  assign w_hit1     = valid_q[1][w_idx] && (tag_q[1][w_idx] == w_tag);
  assign w_hit      = w_hit0 | w_hit1;
  assign w_hit_way  = w_hit1;
  assign w_hit_word = data_q[w_hit_way][w_idx][w_word];
  // Prefer an empty way (way 0 when both are empty), else the LRU way.
  assign w_victim   = !valid_q[0][w_idx] ? 1'b0 :
                      !valid_q[1][w_idx] ? 1'b1 : lru_q[w_idx];
  assign w_last     = (cnt_q == WW'(BLOCK_WORDS - 1));
  assign w_fill_en  = (state_q == S_REFILL) && mem_rvalid && w_last;
  assign w_st_en    = (state_q == S_WRITE) && mem_wr_ack && w_hit;

  always_comb begin
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      w_fill_line[k] = (k == BLOCK_WORDS - 1) ? mem_rdata : buf_q[k];
    end
  end

  always_comb begin
    w_strb      = 4'b1111;
    w_lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        w_strb      = 4'b0001 << addr_q[1:0];
        w_lane_data = {24'b0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
      end
      2'b01: begin
        w_strb      = addr_q[1] ? 4'b1100 : 4'b0011;
        w_lane_data = addr_q[1] ? {wdata_q[15:0], 16'b0} : {16'b0, wdata_q[15:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    valid_d      = valid_q;
    lru_d        = lru_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (we_q) begin
          mem_wr_req_d = 1'b1;
          mem_addr_d   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d  = w_lane_data;
          mem_wstrb_d  = w_strb;
          state_d      = S_WRITE;
        end else if (w_hit) begin
          resp_valid_d  = 1'b1;
          resp_rdata_d  = load_ext(w_hit_word, size_q, addr_q[1:0], uns_q);
          lru_d[w_idx]  = ~w_hit_way;
          state_d       = S_RESPOND;
        end else begin
          mem_rd_req_d = 1'b1;
          mem_addr_d   = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          cnt_d        = '0;
          state_d      = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          buf_d[cnt_q] = mem_rdata;
          cnt_d        = cnt_q + WW'(1);
          if (w_last) begin
            valid_d[w_victim][w_idx] = 1'b1;
            lru_d[w_idx]             = ~w_victim;
            mem_rd_req_d             = 1'b0;
            mem_addr_d               = '0;
            resp_valid_d             = 1'b1;
            resp_rdata_d = load_ext(w_fill_line[w_word], size_q, addr_q[1:0], uns_q);
            state_d      = S_RESPOND;
          end
        end
      end
      S_WRITE: begin
        if (mem_wr_ack) begin
          if (w_hit) lru_d[w_idx] = ~w_hit_way;
          mem_wr_req_d = 1'b0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          mem_wstrb_d  = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          state_d      = S_RESPOND;
        end
      end
      S_RESPOND: begin
        resp_rdata_d = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      buf_q        <= '{default: '0};
      valid_q      <= '0;
      lru_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      valid_q      <= valid_d;
      lru_q        <= lru_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

  // Store hits merge the already lane-shifted write data under the same strobes.
  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        data_q[w_victim][w_idx][k] <= w_fill_line[k];
      end
      tag_q[w_victim][w_idx] <= w_tag;
    end else if (w_st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb_q[b]) data_q[w_hit_way][w_idx][w_word][8*b +: 8] <= mem_wdata_q[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !flush;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule
`default_nettype wire

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised 2-way set-associative, write-through, no-write-allocate data cache for the RV32I data-memory path.
- Replaces the fixed 4-set direct-mapped cache with configurable sets and block size, per-set LRU replacement, a multi-beat refill FSM, and byte/half/word loads and stores.
- Sits between the memory stage (request/response handshake) and data memory (burst-read / single-write port).

Parameters:
- ADDR_WIDTH, 32, byte address width.
- SETS, 4, number of sets. Power of two, at least 2.
- BLOCK_WORDS, 4, 32-bit words per block. Power of two, at least 2.
- Derived fields:
  - OFF = log2(BLOCK_WORDS) + 2
  - IDX = log2(SETS)
  - tag = addr[ADDR_WIDTH-1 : OFF+IDX]
  - index = addr[OFF+IDX-1 : OFF]
  - word = addr[OFF-1 : 2]

Ports:
- clk  in  1  clock, rising edge only.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  cache can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data in the low bits.
- resp_valid  out  1  one-cycle pulse completing a request.
- resp_rdata  out  32  extended load data; 0 for stores.
- flush  in  1  invalidate all lines.
- mem_rd_req  out  1  block read request.
- mem_wr_req  out  1  single-word write request.
- mem_addr  out  ADDR_WIDTH  block-aligned address for reads, word-aligned address for writes.
- mem_wdata  out  32  store data shifted into its byte lane.
- mem_wstrb  out  4  byte enables.
- mem_rvalid  in  1  one refill beat present.
- mem_rdata  in  32  refill word; beats arrive in order 0..BLOCK_WORDS-1.
- mem_wr_ack  in  1  write accepted.

Behaviour:
- Reset:
  - All valid bits and LRU bits are cleared; FSM goes to IDLE.
  - req_ready = 1; resp_valid, mem_rd_req, mem_wr_req = 0; mem_addr, mem_wdata, mem_wstrb, resp_rdata = 0.
  - Reset asserted mid-refill or mid-write abandons the operation. No partial line is left valid. Any late mem_rvalid or mem_wr_ack in IDLE is ignored.
- Per line state: valid, tag, BLOCK_WORDS data words. Per set state: 1 LRU bit naming the way to evict next.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND, WRITE.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, the request is registered and the FSM moves to LOOKUP.
  - If flush is high in IDLE, all valid bits clear at that edge and req_ready is 0 for that cycle; no request is accepted.
  - flush outside IDLE is ignored.
- LOOKUP (compare both ways):
  - Load hit: resp_valid and resp_rdata are driven the next cycle (RESPOND). Load-hit latency is 2 cycles from acceptance. LRU is set to the other way.
  - Load miss: go to REFILL.
  - Store (hit or miss): go to WRITE.
- REFILL:
  - mem_rd_req is held high with mem_addr = req_addr with the low OFF bits cleared.
  - A beat counter advances on each mem_rvalid.
  - After the last beat the victim line is written in full with valid = 1. The victim is the invalid way if exactly one way is invalid, way 0 if both are invalid, otherwise the LRU way.
  - LRU is then set to the other way. mem_rd_req drops and the FSM enters RESPOND with the requested word.
- RESPOND: resp_valid = 1 for exactly one cycle, then IDLE.
- WRITE:
  - mem_wr_req, word-aligned mem_addr, lane-shifted mem_wdata and mem_wstrb are held until mem_wr_ack.
  - On a hit, the cached word is updated with the same byte strobes in the ack cycle and LRU is updated.
  - On a miss, the cache is unchanged (no allocate).
  - resp_valid pulses the cycle after ack; resp_rdata = 0.
- Strobes: byte = 1 << addr[1:0]; half = 0011 << (addr[1] * 2); word = 1111.
- Alignment: half requests ignore addr[0]; word requests ignore addr[1:0]. No misalignment trap is raised.
- Load extraction: select the byte or half at the same lane, then extend per req_unsigned.
- Request inputs are sampled only in the IDLE acceptance cycle and may change afterwards.

Test Plan (SETS=4, BLOCK_WORDS=4; refill of 0x100 returns 0x11110000, 0x22221111, 0x33332222, 0x44443333):
- Cold load word 0x100 -> mem_rd_req with mem_addr = 0x100, 4 beats, resp_rdata = 0x11110000. Then load 0x108 -> resp_valid 2 cycles after acceptance, rdata = 0x33332222, mem_rd_req stays 0.
- LRU conflict: load 0x100, load 0x140, load 0x100 (hit), load 0x180 (evicts 0x140) -> load 0x100 hits; load 0x140 issues mem_rd_req.
- Store byte 0x5A to 0x102 after the 0x100 fill -> mem_wdata = 0x005A0000, mem_wstrb = 0100; hold ack 3 cycles and check request stability. Then load 0x100 -> 0x115A0000 with no refill.
- Extension: memory word 0x000080FF at 0x200. Load byte 0x201 signed -> 0xFFFFFF80; unsigned -> 0x00000080; half 0x200 signed -> 0xFFFF80FF.
- Write miss to 0x300 -> mem_wr_req issued; subsequent load 0x300 misses (no allocate).
- Reset after 2 refill beats -> req_ready = 1, outputs 0; reload 0x100 issues a full 4-beat refill. flush in IDLE followed by load 0x100 -> miss.
